// File: rtl/subneg_data_mem.sv
// -----------------------------------------------------------------------------
// subneg_data_mem
//
// Data memory and operand sequencer for the SUBNEG core. The module holds
// DEPTH words of WIDTH bits. The words are loaded through a preload port. On a
// start request the module runs one SUBNEG data step:
//   A = mem[addr_a], B = mem[addr_b], mem[addr_b] <= B - A (modulo 2^WIDTH).
// It then reports the result together with negative and zero flags, which the
// PC logic uses for its branch decision.
//
// Ports
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset (clears FSM, flags and memory)
//   start_i     request one step; sampled only in IDLE
//   addr_a_i    subtrahend address, latched when start is accepted
//   addr_b_i    minuend / destination address, latched when start is accepted
//   busy_o      high while a step is in flight (LD_A, LD_B, WB)
//   done_o      one-cycle pulse after the write-back edge
//   result_o    last written value B - A
//   neg_o       MSB of result_o (two's-complement sign)
//   zero_o      result_o == 0
//   ld_en_i     preload write enable; honoured only in IDLE
//   ld_addr_i   preload address
//   ld_data_i   preload data
//   rd_addr_i   observe read address
//   rd_data_o   combinational mem[rd_addr_i]
// -----------------------------------------------------------------------------
module subneg_data_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AW-1:0]    addr_a_i,
  input  logic [AW-1:0]    addr_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             neg_o,
  output logic             zero_o,
  input  logic             ld_en_i,
  input  logic [AW-1:0]    ld_addr_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LD_A = 2'd1,
    LD_B = 2'd2,
    WB   = 2'd3
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    a_lat_q;
  logic [AW-1:0]    b_lat_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] result_q;
  logic             neg_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  // Every word must clear on reset, so the storage is a register array and
  // not a RAM macro.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port arbitration and the subtraction result
  logic [WIDTH-1:0] diff_d;
  logic             mem_we_d;
  logic [AW-1:0]    mem_waddr_d;
  logic [WIDTH-1:0] mem_wdata_d;

  // The subtraction wraps modulo 2^WIDTH. When addr_a == addr_b, both
  // operands are the same word, so the difference is zero.
  always_comb begin
    diff_d = op_b_q - op_a_q;
  end

  // The FSM owns the single write port in WB. Preload gets the port only in
  // IDLE. A preload that is requested while busy is dropped, not deferred.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = ld_addr_i;
    mem_wdata_d = ld_data_i;
    if (state_q == WB) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = b_lat_q;
      mem_wdata_d = diff_d;
    end else if (state_q == IDLE && ld_en_i) begin
      mem_we_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Sequencer: IDLE -> LD_A -> LD_B -> WB -> IDLE. All outputs are registered.
  // busy rises on the accept edge and falls on the write-back edge. On that
  // same edge, done rises for a single IDLE cycle. A start in that cycle is
  // accepted at once, so the step throughput is four cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_lat_q <= addr_a_i;
            b_lat_q <= addr_b_i;
            busy_q  <= 1'b1;
            state_q <= LD_A;
          end
        end
        LD_A: begin
          op_a_q  <= mem_q[a_lat_q];
          state_q <= LD_B;
        end
        LD_B: begin
          op_b_q  <= mem_q[b_lat_q];
          state_q <= WB;
        end
        WB: begin
          result_q <= diff_d;
          neg_q    <= diff_d[WIDTH-1];
          zero_q   <= (diff_d == '0);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign neg_o     = neg_q;
  assign zero_o    = zero_q;
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: tb/tb_subneg_data_mem.sv
// -----------------------------------------------------------------------------
// tb_subneg_data_mem
//
// Self-checking bench for subneg_data_mem. It drives a default instance
// (8 x 16) and a wide instance (12 x 64). Expected values come from an
// integer array model that applies the rule mem[b] = (mem[b] - mem[a]) mod 2^W,
// and from a table of hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_subneg_data_mem;

  localparam int W   = 8;
  localparam int D   = 16;
  localparam int AW  = 4;
  localparam int W2  = 12;
  localparam int D2  = 64;
  localparam int AW2 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic          rst_n;
  logic          start, ld_en;
  logic [AW-1:0] addr_a, addr_b, ld_addr, rd_addr;
  logic [W-1:0]  ld_data, result, rd_data;
  logic          busy, done, neg, zero;

  // wide instance
  logic           rst2_n;
  logic           start2, ld_en2;
  logic [AW2-1:0] addr_a2, addr_b2, ld_addr2, rd_addr2;
  logic [W2-1:0]  ld_data2, result2, rd_data2;
  logic           busy2, done2, neg2, zero2;

  subneg_data_mem #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .addr_a_i(addr_a), .addr_b_i(addr_b),
    .busy_o(busy), .done_o(done), .result_o(result), .neg_o(neg), .zero_o(zero),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data)
  );

  subneg_data_mem #(.WIDTH(W2), .DEPTH(D2)) dut2 (
    .clk_i(clk), .rst_ni(rst2_n), .start_i(start2),
    .addr_a_i(addr_a2), .addr_b_i(addr_b2),
    .busy_o(busy2), .done_o(done2), .result_o(result2), .neg_o(neg2), .zero_o(zero2),
    .ld_en_i(ld_en2), .ld_addr_i(ld_addr2), .ld_data_i(ld_data2),
    .rd_addr_i(rd_addr2), .rd_data_o(rd_data2)
  );

  int total = 0;
  int bad   = 0;
  int mdl [D];     // reference memory contents
  int mdl_res;     // reference result of last step

  typedef struct {
    int pa; int pv; int qa; int qv;   // two preloads
    int a;  int b;                    // step operands
    int er; int en; int ez;           // expected result, neg, zero
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there as well.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input int addr, input int data);
    ld_en   = 1'b1;
    ld_addr = AW'(addr);
    ld_data = W'(data);
    tick();
    ld_en   = 1'b0;
    mdl[addr] = data;
  endtask

  // One full step. It can optionally preload on the accept edge, and it
  // checks the cycle-exact busy/done behaviour against the model.
  task automatic run_step(input int a, input int b, input bit with_ld, input int la, input int lv);
    int exp_r;
    start  = 1'b1;
    addr_a = AW'(a);
    addr_b = AW'(b);
    if (with_ld) begin
      ld_en   = 1'b1;
      ld_addr = AW'(la);
      ld_data = W'(lv);
      mdl[la] = lv;
    end
    exp_r = (mdl[b] - mdl[a] + (1 << W)) % (1 << W);
    tick();
    start = 1'b0;
    ld_en = 1'b0;
    check("busy_e0", busy, 1);
    check("done_e0", done, 0);
    tick();
    check("busy_e1", busy, 1);
    tick();
    check("busy_e2", busy, 1);
    tick();
    check("done_e3", done, 1);
    check("busy_e3", busy, 0);
    check("result", result, exp_r);
    check("neg", neg, (exp_r >= (1 << (W-1))) ? 1 : 0);
    check("zero", zero, (exp_r == 0) ? 1 : 0);
    mdl[b]  = exp_r;
    mdl_res = exp_r;
    rd_addr = AW'(b);
    #1 check("mem_b", rd_data, mdl[b]);
    rd_addr = AW'(a);
    #1 check("mem_a", rd_data, mdl[a]);
    $display("step a=%0d b=%0d result=%0h neg=%0b zero=%0b", a, b, result, neg, zero);
    tick();
    check("done_pulse_end", done, 0);
  endtask

  initial begin
    vecs[0] = '{pa:2, pv:5,    qa:3, qv:9,    a:2, b:3, er:8'h04, en:0, ez:0};
    vecs[1] = '{pa:0, pv:10,   qa:1, qv:3,    a:0, b:1, er:8'hF9, en:1, ez:0};
    vecs[2] = '{pa:4, pv:8'h80, qa:5, qv:8'h01, a:4, b:5, er:8'h81, en:1, ez:0};
    vecs[3] = '{pa:7, pv:8'h55, qa:7, qv:8'h55, a:7, b:7, er:8'h00, en:0, ez:1};

    foreach (mdl[i]) mdl[i] = 0;
    mdl_res = 0;

    // ---- reset with start/ld_en asserted ----
    rst_n = 1'b0; rst2_n = 1'b0;
    start = 1'b1; ld_en = 1'b1; ld_addr = 3; ld_data = 8'hFF;
    addr_a = 1; addr_b = 2; rd_addr = 0;
    start2 = 1'b0; ld_en2 = 1'b0; ld_addr2 = 0; ld_data2 = 0;
    addr_a2 = 0; addr_b2 = 0; rd_addr2 = 0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_neg", neg, 0);
    check("rst_zero", zero, 0);
    for (int i = 0; i < D; i++) begin
      rd_addr = AW'(i);
      #1 check("rst_mem", rd_data, 0);
    end
    start = 1'b0; ld_en = 1'b0;
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 4; i++) begin
      load(vecs[i].pa, vecs[i].pv);
      load(vecs[i].qa, vecs[i].qv);
      run_step(vecs[i].a, vecs[i].b, 1'b0, 0, 0);
      check("tab_result", result, vecs[i].er);
      check("tab_neg", neg, vecs[i].en);
      check("tab_zero", zero, vecs[i].ez);
    end
    // mem[2] untouched by first vector
    rd_addr = 2;
    #1 check("tab_mem2", rd_data, 5);

    // ---- preload and start in the same IDLE cycle ----
    load(14, 8'h30);
    run_step(6, 14, 1'b1, 6, 8'h21);
    check("same_cycle_ld", result, 8'h0F);

    // ---- randomized steps against the model ----
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1)
        load($urandom_range(D-1, 0), $urandom_range((1 << W) - 1, 0));
      run_step($urandom_range(D-1, 0), $urandom_range(D-1, 0),
               1'b0, 0, 0);
    end

    // ---- ld_en and start while busy are ignored ----
    load(8, 8'h30);
    load(9, 8'h10);
    load(10, 8'h00);
    start = 1'b1; addr_a = 9; addr_b = 8;
    tick();
    ld_en = 1'b1; ld_addr = 10; ld_data = 8'hAA; addr_a = 0; addr_b = 0;
    tick();
    tick();
    start = 1'b0; ld_en = 1'b0;
    tick();
    check("busy_ign_done", done, 1);
    check("busy_ign_result", result, 8'h20);
    mdl[8] = 8'h20;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("no_second_done", done, 0);
      check("no_second_busy", busy, 0);
      tick();
    end
    rd_addr = 10;
    #1 check("busy_ld_ignored", rd_data, 0);
    rd_addr = 8;
    #1 check("busy_ign_mem8", rd_data, 8'h20);
    $display("protocol busy-ignore result=%0h", result);

    // ---- start held high: chained steps every 4 cycles ----
    load(0, 3);
    load(1, 100);
    start = 1'b1; addr_a = 0; addr_b = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("held_busy", busy, 1);
      tick();
      tick();
      tick();
      mdl[1] = (mdl[1] - mdl[0] + (1 << W)) % (1 << W);
      check("held_done", done, 1);
      check("held_result", result, mdl[1]);
      $display("held step %0d result=%0h", k, result);
    end
    check("held_final", result, 91);
    start = 1'b0;
    tick();
    check("held_stop_busy", busy, 0);
    check("held_stop_done", done, 0);

    // ---- abort by reset during LD_B ----
    load(12, 8'h44);
    load(13, 8'h11);
    start = 1'b1; addr_a = 12; addr_b = 13;
    tick();
    start = 1'b0;
    tick();                       // now in LD_B
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    foreach (mdl[i]) mdl[i] = 0;
    rd_addr = 13;
    #1 check("abort_mem13", rd_data, 0);
    rd_addr = 12;
    #1 check("abort_mem12", rd_data, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_done", done, 0);
    end
    rd_addr = 13;
    #1 check("abort_no_wb", rd_data, 0);
    $display("abort during LD_B done");

    // ---- wide instance: WIDTH=12, DEPTH=64 ----
    ld_en2 = 1'b1; ld_addr2 = 40; ld_data2 = 12'h123;
    tick();
    ld_addr2 = 63; ld_data2 = 12'h100;
    tick();
    ld_en2 = 1'b0;
    start2 = 1'b1; addr_a2 = 40; addr_b2 = 63;
    tick();
    start2 = 1'b0;
    check("w_busy", busy2, 1);
    tick();
    tick();
    tick();
    check("w_done", done2, 1);
    check("w_result", result2, 12'hFDD);
    check("w_neg", neg2, 1);
    check("w_zero", zero2, 0);
    rd_addr2 = 63;
    #1 check("w_mem63", rd_data2, 12'hFDD);
    $display("wide step result=%0h neg=%0b", result2, neg2);
    start2 = 1'b1; addr_a2 = 63; addr_b2 = 40;
    tick();
    start2 = 1'b0;
    tick();
    rst2_n = 1'b0;
    #1;
    check("w_abort_busy", busy2, 0);
    check("w_abort_result", result2, 0);
    rd_addr2 = 40;
    #1 check("w_abort_mem40", rd_data2, 0);
    tick();
    rst2_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("w_abort_no_done", done2, 0);
    end
    $display("wide abort done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
